gpio_port: RTL and testbench

//   Parametrised memory-mapped I/O port: WIDTH-bit bidirectional GPIO bank plus NUM_LEDS on-board LEDs.

---
 rtl/gpio_port.sv | 84 ++++++++
 tb/tb_gpio_port.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
`timescale 1ns/1ps
// gpio_port: memory-mapped GPIO bank + LEDs with synchronised inputs, w1c edge capture and masked irq.
// Define GPIO_EDGE_BOTH_EN to capture falling as well as rising edges.
module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int NUM_LEDS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [2:0]          addr,
  input  logic [WIDTH-1:0]    dataIn,
  input  logic                wrEn,
  input  logic                rdEn,
  output logic [WIDTH-1:0]    dataOut,
  output logic [NUM_LEDS-1:0] LED,
  output logic [WIDTH-1:0]    gpioOutEn,
  output logic [WIDTH-1:0]    gpioOutSig,
  input  logic [WIDTH-1:0]    gpioInSig,
  output logic                irq
);
  logic [WIDTH-1:0] ledReg, dirReg, outReg, edgeReg, imaskReg, prevReg;
  logic [WIDTH-1:0] syncIn, edgeEvt, edgeClr, rdData;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] syncChain;

  assign syncIn = syncChain[SYNC_STAGES-1];
`ifdef GPIO_EDGE_BOTH_EN
  assign edgeEvt = ~dirReg & (syncIn ^ prevReg);
`else
  assign edgeEvt = ~dirReg & syncIn & ~prevReg;
`endif
  assign edgeClr = (wrEn && addr == 3'd4) ? dataIn : '0;

  // a new event in the same cycle as its w1c wins because it is OR-ed after the clear
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      syncChain <= '0;
      prevReg   <= '0;
      edgeReg   <= '0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], gpioInSig};
      prevReg   <= syncIn;
      edgeReg   <= (edgeReg & ~edgeClr) | edgeEvt;
    end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      ledReg   <= '0;
      dirReg   <= '0;
      outReg   <= '0;
      imaskReg <= '0;
    end else if (wrEn) begin
      case (addr)
        3'd0:    ledReg   <= dataIn;
        3'd1:    dirReg   <= dataIn;
        3'd2:    outReg   <= dataIn;
        3'd5:    imaskReg <= dataIn;
        3'd6:    outReg   <= outReg ^ dataIn;
        default: ;
      endcase
    end

  always_comb begin
    rdData = '0;
    case (addr)
      3'd0:    rdData = ledReg;
      3'd1:    rdData = dirReg;
      3'd2:    rdData = outReg;
      3'd3:    rdData = syncIn;
      3'd4:    rdData = edgeReg;
      3'd5:    rdData = imaskReg;
      default: rdData = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) dataOut <= '0;
    else if (rdEn) dataOut <= rdData;

  assign LED        = ledReg[NUM_LEDS-1:0];
  assign gpioOutEn  = dirReg;
  assign gpioOutSig = outReg;
  assign irq        = |(edgeReg & imaskReg);
endmodule

// File: tb/tb_gpio_port.sv
`timescale 1ns/1ps
// tb_gpio_port: random + directed bench for gpio_port against a pin-history register model.
module tb_gpio_port;
  localparam int W  = 8;
  localparam int NL = 4;
  localparam int SS = 2;
`ifdef GPIO_EDGE_BOTH_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic [2:0] addr = '0;
  logic [W-1:0] dataIn = '0, gpioInSig = '0;
  logic wrEn = 1'b0, rdEn = 1'b0;
  logic [W-1:0] dataOut, gpioOutEn, gpioOutSig;
  logic [NL-1:0] LED;
  logic irq;

  int checks = 0, errors = 0;

  gpio_port #(.WIDTH(W), .NUM_LEDS(NL), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RST_N(RST_N), .addr(addr), .dataIn(dataIn), .wrEn(wrEn), .rdEn(rdEn),
    .dataOut(dataOut), .LED(LED), .gpioOutEn(gpioOutEn), .gpioOutSig(gpioOutSig),
    .gpioInSig(gpioInSig), .irq(irq)
  );

  always #5 CLK = ~CLK;

  // model: registers as plain variables, IN taken from a history of sampled pin values
  logic [W-1:0] mLed = '0, mDir = '0, mOut = '0, mEdge = '0, mImask = '0, mData = '0;
  logic [W-1:0] hist [0:SS];
  logic [W-1:0] mIn, mPrev, mEvt, mRd, mClr;

  function automatic logic [W-1:0] modelRead(input logic [2:0] a);
    case (a)
      3'd0: return mLed;
      3'd1: return mDir;
      3'd2: return mOut;
      3'd3: return hist[SS-1];
      3'd4: return mEdge;
      3'd5: return mImask;
      default: return '0;
    endcase
  endfunction

  initial begin
    for (int i = 0; i <= SS; i++) hist[i] = '0;
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        mLed = '0; mDir = '0; mOut = '0; mEdge = '0; mImask = '0; mData = '0;
        for (int i = 0; i <= SS; i++) hist[i] = '0;
      end else begin
        mIn   = hist[SS-1];
        mPrev = hist[SS];
        mEvt  = ~mDir & (BOTH ? (mIn ^ mPrev) : (mIn & ~mPrev));
        mRd   = modelRead(addr);
        for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = gpioInSig;
        if (rdEn) mData = mRd;
        mClr  = (wrEn && addr == 3'd4) ? dataIn : '0;
        mEdge = (mEdge & ~mClr) | mEvt;
        if (wrEn)
          case (addr)
            3'd0: mLed = dataIn;
            3'd1: mDir = dataIn;
            3'd2: mOut = dataIn;
            3'd5: mImask = dataIn;
            3'd6: mOut = mOut ^ dataIn;
            default: ;
          endcase
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("model dataOut", dataOut, mData);
    chk("model LED", W'(LED), W'(mLed[NL-1:0]));
    chk("model gpioOutEn", gpioOutEn, mDir);
    chk("model gpioOutSig", gpioOutSig, mOut);
    chk("model irq", W'(irq), W'(|(mEdge & mImask)));
  end

  task automatic bus(input logic w, input logic r, input logic [2:0] a, input logic [W-1:0] d);
    wrEn = w; rdEn = r; addr = a; dataIn = d;
    @(negedge CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 3'd0, W'($urandom));
  endtask

  initial begin
    #1 RST_N = 1'b0;
    @(negedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      gpioInSig = W'($urandom);
      bus(1'($urandom), 1'($urandom), 3'($urandom), W'($urandom));
    end
    chk("reset LED", W'(LED), '0);
    chk("reset gpioOutEn", gpioOutEn, '0);
    chk("reset gpioOutSig", gpioOutSig, '0);
    chk("reset irq", W'(irq), '0);
    chk("reset dataOut", dataOut, '0);
    gpioInSig = '0;
    RST_N = 1'b1;
    idle(SS + 2);
    for (int a = 0; a < 8; a++) begin
      bus(1'b0, 1'b1, 3'(a), W'($urandom));
      chk($sformatf("read after reset a%0d", a), dataOut, '0);
    end

    bus(1'b1, 1'b0, 3'd1, 8'hF0);
    bus(1'b1, 1'b0, 3'd2, 8'hA5);
    bus(1'b1, 1'b0, 3'd6, 8'h0F);
    chk("dir out", gpioOutEn, 8'hF0);
    chk("toggle out", gpioOutSig, 8'hAA);
    bus(1'b0, 1'b1, 3'd2, '0);
    chk("read OUT", dataOut, 8'hAA);
    bus(1'b0, 1'b0, 3'd0, '0);
    chk("dataOut hold", dataOut, 8'hAA);

    gpioInSig = 8'h08;
    bus(1'b1, 1'b0, 3'd5, 8'h08);
    bus(1'b0, 1'b0, 3'd0, '0);
    chk("irq before capture", W'(irq), '0);
    bus(1'b0, 1'b1, 3'd3, '0);
    chk("IN after sync", dataOut, 8'h08);
    chk("irq on capture", W'(irq), 1);
    bus(1'b0, 1'b1, 3'd4, '0);
    chk("EDGE pin3", dataOut, 8'h08);
    bus(1'b1, 1'b0, 3'd4, 8'h08);
    chk("irq after w1c", W'(irq), '0);

    gpioInSig = 8'h00;
    idle(4);
    bus(1'b1, 1'b0, 3'd4, 8'hFF);
    chk("irq cleared", W'(irq), '0);
    gpioInSig = 8'h08;
    idle(2);
    bus(1'b1, 1'b0, 3'd4, 8'h08);
    chk("set beats w1c irq", W'(irq), 1);
    bus(1'b0, 1'b1, 3'd4, '0);
    chk("set beats w1c EDGE", dataOut, 8'h08);

    bus(1'b1, 1'b0, 3'd4, 8'hFF);
    gpioInSig = 8'h0C;
    idle(4);
    bus(1'b1, 1'b0, 3'd4, 8'hFF);
    gpioInSig = 8'h08;
    for (int i = 0; i < 4; i++) begin
      gpioInSig ^= 8'h20;
      idle(1);
    end
    idle(3);
    bus(1'b0, 1'b1, 3'd4, '0);
    chk("fall pin2 / out pin5", dataOut, BOTH ? 8'h04 : 8'h00);

    bus(1'b1, 1'b0, 3'd0, 8'hB7);
    chk("LED low bits", W'(LED), 8'h07);
    bus(1'b0, 1'b1, 3'd0, '0);
    chk("LED readback", dataOut, 8'hB7);
    bus(1'b1, 1'b0, 3'd7, 8'h5A);
    bus(1'b0, 1'b1, 3'd7, '0);
    chk("reserved reads 0", dataOut, '0);
    bus(1'b0, 1'b1, 3'd6, '0);
    chk("TOGGLE reads 0", dataOut, '0);
    bus(1'b1, 1'b0, 3'd3, 8'hFF);
    bus(1'b0, 1'b1, 3'd3, '0);
    chk("IN write ignored", dataOut, 8'h08);
    bus(1'b1, 1'b1, 3'd5, 8'h3C);
    chk("read pre-write", dataOut, 8'h08);
    bus(1'b0, 1'b1, 3'd5, '0);
    chk("read post-write", dataOut, 8'h3C);

    bus(1'b1, 1'b0, 3'd1, 8'h00);
    bus(1'b1, 1'b0, 3'd5, 8'hFF);
    gpioInSig = 8'h00;
    idle(4);
    bus(1'b1, 1'b0, 3'd4, 8'hFF);
    gpioInSig = 8'hFF;
    idle(4);
    bus(1'b0, 1'b1, 3'd4, '0);
    chk("EDGE all", dataOut, 8'hFF);
    chk("irq all", W'(irq), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("async irq", W'(irq), '0);
    chk("async dataOut", dataOut, '0);
    chk("async LED", W'(LED), '0);
    chk("async gpioOutSig", gpioOutSig, '0);
    @(negedge CLK); #1;
    idle(2);
    RST_N = 1'b1;
    idle(SS + 3);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) gpioInSig ^= W'($urandom);
      if (c % 500 == 499) begin
        #2 RST_N = 1'b0;
        @(negedge CLK); #1;
        RST_N = 1'b1;
      end
      bus($urandom_range(9) < 3, $urandom_range(1) == 1, 3'($urandom), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
